// File: rtl/mmio_responder_if.sv
// Bus bundle for mmio_responder: CPU data-port strobes plus the console byte stream.
// master = CPU/console side, slave = the responder.
interface mmio_responder_if;
   logic [29:0] addr;
   logic [31:0] din;
   logic        re;
   logic        we;
   logic [31:0] dout;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output addr, din, re, we, tx_ready,
      input  dout, tx_data, tx_valid
   );

   modport slave (
      input  addr, din, re, we, tx_ready,
      output dout, tx_data, tx_valid
   );
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: console TX FIFO, 64-bit cycle counter with CYCLE_HI shadow, scratch register.
// The counter and shadow exist only when MMIO_CYCLE_COUNTER_EN is defined; otherwise both read 0.
module mmio_responder #(
   parameter logic [29:0] BASE  = 30'h0400_0000,
   parameter int          DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   mmio_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] OFF_STATUS  = 3'd0;
   localparam logic [2:0] OFF_TXDATA  = 3'd1;
   localparam logic [2:0] OFF_CYC_LO  = 3'd2;
   localparam logic [2:0] OFF_CYC_HI  = 3'd3;
   localparam logic [2:0] OFF_SCRATCH = 3'd4;

   logic          hit;
   logic [2:0]    off;
   logic          rd_hit;
   logic          wr_hit;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   scratch_q, scratch_d;
   logic [31:0]   dout_q, dout_d;

   logic          full;
   logic          empty;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          ovf_clr;
   logic [31:0]   status;
   logic [31:0]   cyc_lo;
   logic [31:0]   cyc_hi;

   assign hit    = (bus.addr[29:3] == BASE[29:3]);
   assign off    = bus.addr[2:0];
   assign rd_hit = bus.re && hit;
   assign wr_hit = bus.we && hit;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign status = {16'h0000, 8'(count_q), 5'b00000, ovf_q, empty, full};

   // Head byte is taken straight from the buffer; masked to 0 while empty so stale entries never show.
   assign bus.tx_valid = !empty;
   assign bus.tx_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign bus.dout     = dout_q;

   always_comb begin
      pop       = bus.tx_valid && bus.tx_ready;
      push_req  = wr_hit && (off == OFF_TXDATA);
      push_ok   = push_req && (!full || pop);
      ovf_clr   = wr_hit && (off == OFF_STATUS) && bus.din[2];

      wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A refused push in the same cycle as a clear leaves overflow set.
      ovf_d = ovf_q;
      if (ovf_clr)             ovf_d = 1'b0;
      if (push_req && !push_ok) ovf_d = 1'b1;

      scratch_d = (wr_hit && (off == OFF_SCRATCH)) ? bus.din : scratch_q;

      dout_d = 32'h0000_0000;
      if (rd_hit) begin
         case (off)
            OFF_STATUS:  dout_d = status;
            OFF_CYC_LO:  dout_d = cyc_lo;
            OFF_CYC_HI:  dout_d = cyc_hi;
            OFF_SCRATCH: dout_d = scratch_q;
            default:     dout_d = 32'h0000_0000;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         scratch_q <= 32'h0000_0000;
         dout_q    <= 32'h0000_0000;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         scratch_q <= scratch_d;
         dout_q    <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= bus.din[7:0];
   end

`ifdef MMIO_CYCLE_COUNTER_EN
   logic [63:0] cycle_q, cycle_d;
   logic [31:0] shadow_q, shadow_d;

   // Shadow captures the high word at the CYCLE_LO read edge so the 64-bit pair stays coherent.
   always_comb begin
      cycle_d  = cycle_q + 64'd1;
      shadow_d = (rd_hit && (off == OFF_CYC_LO)) ? cycle_q[63:32] : shadow_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q  <= 64'd0;
         shadow_q <= 32'h0000_0000;
      end else begin
         cycle_q  <= cycle_d;
         shadow_q <= shadow_d;
      end
   end

   assign cyc_lo = cycle_q[31:0];
   assign cyc_hi = shadow_q;
`else
   assign cyc_lo = 32'h0000_0000;
   assign cyc_hi = 32'h0000_0000;
`endif

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped peripheral responder on the CPU's word-addressed data port. It answers the same read/write strobes as the RAM and has the same one-cycle read latency, so the top level can OR its read data with the RAM's. It holds three things: a byte FIFO that feeds an external console consumer, a 64-bit free-running cycle counter with a coherent high-word shadow, and a scratch register.

## Interface
Parameters:
- `BASE`, default 30'h0400_0000: word address of the register window; must be 8-word aligned (byte address 0x1000_0000).
- `DEPTH`, default 16: TX FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr`  in  30  word address from the CPU's RAM address mux.
- `din`  in  32  write data (CPU r2).
- `re`  in  1  read strobe.
- `we`  in  1  write strobe.
- `dout`  out  32  registered read data; 0 when the previous cycle was not a read hit.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head byte.

## Operation
- Hit: `addr[29:3] == BASE[29:3]`. The offset is `addr[2:0]`. Strobes that miss have no effect.
- Register map:
  - Offset 0, STATUS (R/W):
    - Read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[15:8] FIFO count; all other bits 0.
    - Write: `din[2]`=1 clears overflow; other bits ignored.
  - Offset 1, TXDATA (W): pushes `din[7:0]`. Reads return 0.
  - Offset 2, CYCLE_LO (R): returns counter[31:0]. The same read also latches counter[63:32] into the shadow.
  - Offset 3, CYCLE_HI (R): returns the shadow.
  - Offset 4, SCRATCH (R/W): 32-bit storage.
  - Offsets 5–7: read 0; writes ignored.
- FIFO:
  - Circular buffer with read and write pointers and a count of width clog2(DEPTH)+1.
  - Pop happens when `tx_valid && tx_ready`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - A push that is refused is dropped and sets overflow.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Counter: increments by 1 every cycle out of reset and wraps modulo 2^64.
- `re` and `we` in the same cycle to the same offset: the write takes effect, and `dout` returns the pre-write value.
- Overflow set and clear in the same cycle: set wins.
- Reset values:
  - `dout`=0, `tx_valid`=0, `tx_data`=0.
  - Counter, shadow, scratch, pointers, count and overflow all 0.
- Reset mid-operation discards all FIFO contents immediately. No byte is presented afterward until a new push.

## Timing
- Read latency is 1 cycle: `re` and a hit at edge N give `dout` valid after edge N, and it holds for one cycle only.
- A read with no hit, or no read, drives `dout`=0 after the next edge.
- CYCLE_LO returns the counter value sampled at the read edge (pre-increment). The shadow latches at the same edge.
- Write to TXDATA at edge N: `tx_valid` rises after edge N when the FIFO was empty, so fall-through latency is 1 cycle.
- `tx_data` and `tx_valid` are registered or pointer-derived and change only on `clk` edges. There is no combinational path from `tx_ready` to `tx_valid`.
- STATUS reflects state before the current edge's updates.

## Configuration
- `MMIO_CYCLE_COUNTER_EN` defined: the counter and shadow are implemented as described above.
- Undefined:
  - No counter or shadow flops are built.
  - CYCLE_LO and CYCLE_HI read 0.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read STATUS: `dout`=32'h0000_0002 (empty) one cycle after `re`; `tx_valid`=0.
- Write 8'h41 to TXDATA with `tx_ready`=0: `tx_valid`=1 and `tx_data`=8'h41 next cycle. STATUS then reads 32'h0000_0100.
- Push 17 bytes with `tx_ready`=0 at DEPTH=16:
  - The 17th byte is dropped and STATUS reads 32'h0000_1005.
  - Write STATUS with `din`=4 → 32'h0000_1001.
  - Drain with `tx_ready`=1 → bytes come out in order and `tx_valid` falls after 16 pops.
- Full FIFO, push and pop in the same cycle: the push is accepted, the count stays at 16 and overflow stays 0.
- Preload the counter to 64'h0000_0000_FFFF_FFFF via force:
  - Read CYCLE_LO → 32'hFFFF_FFFF.
  - Read CYCLE_HI later → 0 (shadow), not 1.
  - Without the macro, both read 0.
- Write SCRATCH 32'hDEADBEEF, then read it → 32'hDEADBEEF. A write at BASE+8 (miss) and an offset-6 read (→0) do not change it.
